// File: rtl/training_sample_sequencer_pkg.sv
// Shared data type, layer constants, dataset defaults and FSM encoding for the
// training sample sequencer.
package training_sample_sequencer_pkg;

    typedef logic signed [15:0] data_type;

    localparam int unsigned L1 = 2;
    localparam int unsigned L2 = 4;
    localparam int unsigned L3 = 4;
    localparam int unsigned L4 = 1;

    localparam int unsigned SIZE_OF_X_DEFAULT = 2048;
    localparam int unsigned EPOCHS_DEFAULT    = 100;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPresent,
        StDone
    } seq_state_e;

    // Galois tap masks for maximal-length LFSRs; widths outside the table fall back
    // to a single MSB tap, which still never locks up on a non-zero seed.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            default: return 32'h0000_0001 << (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/training_sample_sequencer_lfsr.sv
// sample_lfsr: Galois LFSR producing the per-epoch address mask. Exposes the
// next-state mask so the address register can load idx ^ mask in the same edge.
module sample_lfsr
    import training_sample_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned SEED  = 'h5A5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] mask_next
);

    localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [31:0]      SEED_FULL = SEED;
    localparam logic [WIDTH-1:0] SEED_W    = SEED_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] stepped;

    always_comb begin
        stepped = mask_q >> 1;
        if (mask_q[0]) begin
            stepped = stepped ^ TAPS;
        end
        mask_next = step ? stepped : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= SEED_W;
        end else begin
            mask_q <= mask_next;
        end
    end

endmodule

// File: rtl/training_sample_sequencer.sv
// Walks the training set sample by sample and epoch by epoch, presenting each sample
// over valid/ready. Define SAMPLE_SHUFFLE_EN to XOR addresses with a per-epoch LFSR mask.
module training_sample_sequencer
    import training_sample_sequencer_pkg::*;
#(
    parameter int unsigned SIZE_OF_X = SIZE_OF_X_DEFAULT,
    parameter int unsigned EPOCHS    = EPOCHS_DEFAULT,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned EP_W      = 8,
    parameter int unsigned LFSR_SEED = 'h5A5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] address,
    input  data_type          X0,
    input  data_type          X1,
    input  data_type          Y,
    output data_type          a1_0,
    output data_type          a1_1,
    output data_type          y_0,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              epoch_done,
    output logic [EP_W-1:0]   epoch,
    output logic              train_done
);

    if (SIZE_OF_X != (32'd1 << ADDR_W)) begin : g_bad_size
        $error("SIZE_OF_X must equal 2**ADDR_W");
    end
    if (EPOCHS == 0 || EPOCHS >= (32'd1 << EP_W)) begin : g_bad_epochs
        $error("EPOCHS must be non-zero and below 2**EP_W");
    end
    if (LFSR_SEED == 0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(SIZE_OF_X - 1);
    localparam logic [EP_W-1:0]   LAST_EPOCHS = EP_W'(EPOCHS);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    data_type          a1_0_q, a1_0_d, a1_1_q, a1_1_d, y_0_q, y_0_d;
    logic              valid_q, valid_d;
    logic              epoch_done_q, epoch_done_d;
    logic [EP_W-1:0]   epoch_q, epoch_d;
    logic              train_done_q, train_done_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a1_0_d       = a1_0_q;
        a1_1_d       = a1_1_q;
        y_0_d        = y_0_q;
        valid_d      = valid_q;
        epoch_done_d = 1'b0;
        epoch_d      = epoch_q;
        train_done_d = train_done_q;

        unique case (state_q)
            StIdle: begin
                if (enable && !train_done_q) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                a1_0_d  = X0;
                a1_1_d  = X1;
                y_0_d   = Y;
                valid_d = 1'b1;
                state_d = StPresent;
            end
            StPresent: begin
                if (valid_q && sample_ready) begin
                    valid_d = 1'b0;
                    idx_d   = idx_q + 1'b1;
                    state_d = enable ? StFetch : StIdle;
                    if (idx_q == LAST_IDX) begin
                        epoch_done_d = 1'b1;
                        epoch_d      = epoch_q + 1'b1;
                        if (epoch_d == LAST_EPOCHS) begin
                            train_done_d = 1'b1;
                            state_d      = StDone;
                        end
                    end
                end
            end
            StDone: begin
                valid_d      = 1'b0;
                train_done_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef SAMPLE_SHUFFLE_EN
    localparam logic [31:0]       SEED_FULL  = LFSR_SEED;
    localparam logic [ADDR_W-1:0] ADDR_RESET = SEED_FULL[ADDR_W-1:0];

    logic [ADDR_W-1:0] mask_next;

    // The mask steps on the same edge that wraps idx, so the first address of a
    // new epoch already carries the new mask.
    sample_lfsr #(
        .WIDTH(ADDR_W),
        .SEED (LFSR_SEED)
    ) u_sample_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (epoch_done_d),
        .mask_next(mask_next)
    );

    assign addr_d = idx_d ^ mask_next;
`else
    localparam logic [ADDR_W-1:0] ADDR_RESET = '0;

    assign addr_d = idx_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            addr_q       <= ADDR_RESET;
            a1_0_q       <= '0;
            a1_1_q       <= '0;
            y_0_q        <= '0;
            valid_q      <= 1'b0;
            epoch_done_q <= 1'b0;
            epoch_q      <= '0;
            train_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            a1_0_q       <= a1_0_d;
            a1_1_q       <= a1_1_d;
            y_0_q        <= y_0_d;
            valid_q      <= valid_d;
            epoch_done_q <= epoch_done_d;
            epoch_q      <= epoch_d;
            train_done_q <= train_done_d;
        end
    end

    assign address      = addr_q;
    assign a1_0         = a1_0_q;
    assign a1_1         = a1_1_q;
    assign y_0          = y_0_q;
    assign sample_valid = valid_q;
    assign epoch_done   = epoch_done_q;
    assign epoch        = epoch_q;
    assign train_done   = train_done_q;

endmodule

// File: tb/tb_training_sample_sequencer.sv
// Scoreboard bench for training_sample_sequencer with a 4-sample, 2-epoch dataset
// backed by a one-cycle-latency memory model.
module tb_training_sample_sequencer;
    import training_sample_sequencer_pkg::*;

    localparam int unsigned SX = 4;
    localparam int unsigned EP = 2;
    localparam int unsigned AW = 2;
    localparam int unsigned EW = 8;

`ifdef SAMPLE_SHUFFLE_EN
    localparam logic [AW-1:0] MASKS [3] = '{2'd1, 2'd3, 2'd2};
`else
    localparam logic [AW-1:0] MASKS [3] = '{2'd0, 2'd0, 2'd0};
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        data_type      x0;
        data_type      x1;
        data_type      y;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          sample_ready = 1'b0;
    logic [AW-1:0] address;
    data_type      X0, X1, Y;
    data_type      a1_0, a1_1, y_0;
    logic          sample_valid, epoch_done, train_done;
    logic [EW-1:0] epoch;

    exp_t sb_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   base;

    always #5 clk = ~clk;

    training_sample_sequencer #(
        .SIZE_OF_X(SX),
        .EPOCHS   (EP),
        .ADDR_W   (AW),
        .EP_W     (EW),
        .LFSR_SEED('h5A5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .address     (address),
        .X0          (X0),
        .X1          (X1),
        .Y           (Y),
        .a1_0        (a1_0),
        .a1_1        (a1_1),
        .y_0         (y_0),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .epoch_done  (epoch_done),
        .epoch       (epoch),
        .train_done  (train_done)
    );

    // Synchronous dataset memory: X0 = 10+addr, X1 = 50-addr, Y = 3*addr.
    always @(posedge clk) begin
        X0 <= data_type'(10 + int'(address));
        X1 <= data_type'(50 - int'(address));
        Y  <= data_type'(3 * int'(address));
    end

    function automatic logic [AW-1:0] exp_addr(input int idx, input int ep);
        return AW'(idx) ^ MASKS[ep % 3];
    endfunction

    function automatic exp_t exp_sample(input int idx, input int ep);
        exp_t r;
        r.addr = exp_addr(idx, ep);
        r.x0   = data_type'(10 + int'(r.addr));
        r.x1   = data_type'(50 - int'(r.addr));
        r.y    = data_type'(3 * int'(r.addr));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int idx0, input int ep0);
        for (int ep = ep0; ep < int'(EP); ep++) begin
            for (int i = (ep == ep0) ? idx0 : 0; i < int'(SX); i++) begin
                sb_q.push_back(exp_sample(i, ep));
            end
        end
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n = 0;
        while (!sample_valid && n < limit) begin
            step();
            n++;
        end
        check(name, 32'(sample_valid), 32'd1);
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (!train_done && n < limit) begin
            step();
            n++;
        end
        check(name, 32'(train_done), 32'd1);
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (epoch_done) pulses++;
            if (sample_valid && sample_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample: got a1_0=%0d want no sample", a1_0);
                end else begin
                    e = sb_q.pop_front();
                    check("sample_addr", 32'(address), 32'(e.addr));
                    check("sample_a1_0", 32'(a1_0), 32'(e.x0));
                    check("sample_a1_1", 32'(a1_1), 32'(e.x1));
                    check("sample_y_0", 32'(y_0), 32'(e.y));
                end
            end
        end
    end

    initial begin
        // Reset held 10 cycles, released with enable low.
        repeat (10) step();
        reset = 1'b1;
        repeat (3) step();
        check("rst_addr", 32'(address), 32'(exp_addr(0, 0)));
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_epoch_done", 32'(epoch_done), 32'd0);
        check("rst_epoch", 32'(epoch), 32'd0);
        check("rst_train_done", 32'(train_done), 32'd0);
        check("rst_a1_0", 32'(a1_0), 32'd0);
        check("rst_y_0", 32'(y_0), 32'd0);

        // Backpressure on the first sample, then a full two-epoch run.
        base = pulses;
        enable = 1'b1;
        sb_q.push_back(exp_sample(0, 0));
        wait_valid(10, "first_valid");
        repeat (5) begin
            step();
            check("bp_valid", 32'(sample_valid), 32'd1);
            check("bp_a1_0", 32'(a1_0), 32'(10 + int'(exp_addr(0, 0))));
            check("bp_addr", 32'(address), 32'(exp_addr(0, 0)));
        end
        push_run(1, 0);
        sample_ready = 1'b1;
        wait_done(60, "run_train_done");
        repeat (5) step();
        check("done_epoch", 32'(epoch), 32'd2);
        check("done_flag", 32'(train_done), 32'd1);
        check("done_valid", 32'(sample_valid), 32'd0);
        check("done_pulses", 32'(pulses - base), 32'd2);
        check("done_sb_empty", 32'(sb_q.size()), 32'd0);

        // Enable dropped while idx 1 is presented.
        reset = 1'b0;
        repeat (3) step();
        sample_ready = 1'b0;
        enable = 1'b1;
        reset = 1'b1;
        sb_q.push_back(exp_sample(0, 0));
        sb_q.push_back(exp_sample(1, 0));
        wait_valid(10, "en_idx0_valid");
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        wait_valid(10, "en_idx1_valid");
        enable = 1'b0;
        step();
        check("en_hold_valid", 32'(sample_valid), 32'd1);
        check("en_hold_a1_0", 32'(a1_0), 32'(10 + int'(exp_addr(1, 0))));
        sample_ready = 1'b1;
        step();
        repeat (5) step();
        check("idle_valid", 32'(sample_valid), 32'd0);
        check("idle_addr", 32'(address), 32'(exp_addr(2, 0)));
        check("idle_sb_empty", 32'(sb_q.size()), 32'd0);
        sample_ready = 1'b0;
        enable = 1'b1;
        wait_valid(10, "resume_valid");
        check("resume_a1_0", 32'(a1_0), 32'(10 + int'(exp_addr(2, 0))));
        check("resume_addr", 32'(address), 32'(exp_addr(2, 0)));

        // Asynchronous reset mid-cycle while idx 2 is presented.
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(sample_valid), 32'd0);
        check("async_a1_0", 32'(a1_0), 32'd0);
        check("async_addr", 32'(address), 32'(exp_addr(0, 0)));
        check("async_epoch", 32'(epoch), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        base = pulses;
        push_run(0, 0);
        sample_ready = 1'b1;
        wait_done(60, "rerun_train_done");
        repeat (3) step();
        check("rerun_epoch", 32'(epoch), 32'd2);
        check("rerun_pulses", 32'(pulses - base), 32'd2);
        check("rerun_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/training_sample_sequencer.md
# training_sample_sequencer

Upstream feeder for `top_neural_network` during on-chip training. Walks the training-set memory sample by sample and epoch by epoch, registers each sample's inputs and expected output, and presents them to the network over a valid/ready handshake. It owns the dataset address counter and epoch counter, and signals when training is complete.

## Interface

**Parameters**
- `SIZE_OF_X`, default 2048: samples per epoch; must be a power of two.
- `EPOCHS`, default 100: number of epochs before `train_done`.
- `ADDR_W`, default 11: address width; must equal log2(`SIZE_OF_X`).
- `EP_W`, default 8: epoch counter width.
- `LFSR_SEED`, default 11'h5A5: non-zero seed, used only when shuffle is compiled in.

**Ports**
- `clk`, input, 1: single clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low.
- `enable`, input, 1: run permission, level-sensitive.
- `address`, output, `ADDR_W`: dataset memory address.
- `X0`, input, `data_type`: memory feature 0, valid 1 cycle after `address`.
- `X1`, input, `data_type`: memory feature 1, same timing as `X0`.
- `Y`, input, `data_type`: memory expected output, same timing as `X0`.
- `a1_0`, output, `data_type`: registered feature 0 to the network.
- `a1_1`, output, `data_type`: registered feature 1 to the network.
- `y_0`, output, `data_type`: registered expected output to the network.
- `sample_valid`, output, 1: the sample on `a1_0`/`a1_1`/`y_0` is valid.
- `sample_ready`, input, 1: the network accepts the sample.
- `epoch_done`, output, 1: one-cycle pulse on acceptance of an epoch's last sample.
- `epoch`, output, `EP_W`: number of completed epochs.
- `train_done`, output, 1: sticky; asserted once `EPOCHS` epochs are complete.

## Operation

**FSM states:** IDLE, FETCH, LOAD, PRESENT, DONE.
- IDLE: go to FETCH when `enable` is 1 and `train_done` is 0.
- FETCH: `address` is already driven. Wait one cycle for the synchronous memory, then go to LOAD.
- LOAD: capture `X0`/`X1`/`Y` into `a1_0`/`a1_1`/`y_0`. Set `sample_valid` to 1. Go to PRESENT.
- PRESENT: hold data and `sample_valid` stable until `sample_valid && sample_ready`. On that handshake cycle:
  - Clear `sample_valid`.
  - Increment `idx` (wraps mod `SIZE_OF_X`).
  - If `idx == SIZE_OF_X-1`: pulse `epoch_done` and increment `epoch`. If the new `epoch == EPOCHS`, go to DONE.
  - Otherwise, go to FETCH if `enable` is 1, or to IDLE if it is 0.
- DONE: `train_done` is 1 and `sample_valid` is 0. The only exit is reset.

**Address rule:** `address` = f(`idx`, epoch), where f is defined under Configuration. It is registered and changes only on handshake.

**Enable:** deasserting `enable` never drops a presented sample. PRESENT completes its handshake, then the FSM parks in IDLE with `idx` retained.

**Arithmetic:** unsigned counters with no saturation. `epoch` never exceeds `EPOCHS` (a static assertion checks `EPOCHS < 2**EP_W`). Sample data passes through unmodified.

**Reset values (mid-operation reset aborts immediately):** `address` = 0, or the shuffle mask with shuffle compiled in; `idx` = 0; all data outputs = 0; `sample_valid` = 0; `epoch_done` = 0; `epoch` = 0; `train_done` = 0; state = IDLE.

## Timing
- Start latency: `enable` sampled 1 in IDLE at cycle n gives `sample_valid` = 1 at cycle n+2, after FETCH and LOAD.
- Throughput: with `sample_ready` tied to 1, one sample per 3 cycles (FETCH, LOAD, PRESENT).
- `epoch_done` is high in the cycle after the final handshake of each epoch, for exactly one cycle.
- `train_done` rises in that same cycle on the final epoch.
- `sample_ready` asserted while `sample_valid` is 0 is ignored.

## Configuration
- Macro: `SAMPLE_SHUFFLE_EN`.
- **Defined:**
  - An `ADDR_W`-bit Galois LFSR holds `mask`. It resets to `LFSR_SEED` and steps once per `epoch_done`.
  - `address` = `idx ^ mask`. Each epoch is therefore a permutation of all `SIZE_OF_X` samples, since XOR with a constant is a bijection.
- **Undefined:** no LFSR; `address` = `idx`.

## Structure
- Shared typedef header: `data_type` and layer constants `L1`–`L4`.
- `forward_net_header.vh` additionally holds `SIZE_OF_X` and `EPOCHS` defaults.
- One sub-module, `sample_lfsr`: the mask generator, instantiated only under `SAMPLE_SHUFFLE_EN`.

## Test plan
1. Reset held low 10 cycles, then released with `enable` = 0: all outputs hold their reset values and `address` stays at 0 (or the seed when shuffled).
2. `SIZE_OF_X` = 4, `EPOCHS` = 2, `sample_ready` = 1, memory holding `X0` = 10+addr: the network sees `a1_0` = 10, 11, 12, 13, 10, 11, 12, 13. `epoch_done` pulses twice, and `train_done` = 1 with `epoch` = 2 after 24 cycles.
3. Backpressure: `sample_ready` held 0 for 5 cycles in PRESENT. Data and `sample_valid` stay stable, and `address` does not change.
4. `enable` dropped mid-PRESENT: the current sample is accepted, then the FSM sits in IDLE. Re-enabling resumes at `idx` + 1 with no sample lost or repeated.
5. Async reset asserted mid-epoch at `idx` = 2: outputs clear immediately without waiting for a clock edge, and the run restarts at `idx` = 0, `epoch` = 0.
6. `SAMPLE_SHUFFLE_EN` with `SIZE_OF_X` = 8: each epoch visits all 8 addresses exactly once, and the visit order differs between epoch 0 and epoch 1.
